// File: rtl/hazard_unit_multicycle.sv
// Load-use / memory-freeze / branch-flush hazard controller for the 5-stage pipe.
// Optional perf counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_unit_multicycle #(
   parameter int REG_AW      = 5,
   parameter int LOAD_STALLS = 1,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              branch_taken,
   input  logic              dmem_busy,
   output logic              pc_hold,
   output logic              ifd_hold,
   output logic              de_hold,
   output logic              em_hold,
   output logic              de_bubble,
   output logic              ifd_flush,
   output logic [1:0]        stall_state,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1
   } state_t;

   localparam logic [3:0] INIT_REMAIN = 4'(LOAD_STALLS - 1);

   state_t     state_q, state_d;
   logic [3:0] remain_q, remain_d;
   logic       hazard_hit;

   // x0 is hardwired zero, so a load targeting it can never create a dependency
   assign hazard_hit = ex_is_load && (ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      pc_hold   = 1'b0;
      ifd_hold  = 1'b0;
      de_hold   = 1'b0;
      em_hold   = 1'b0;
      de_bubble = 1'b0;
      ifd_flush = 1'b0;
      if (reset) begin
         state_d  = IDLE;
         remain_d = '0;
      end else if (dmem_busy) begin
         pc_hold  = 1'b1;
         ifd_hold = 1'b1;
         de_hold  = 1'b1;
         em_hold  = 1'b1;
      end else if (branch_taken) begin
         ifd_flush = 1'b1;
         de_bubble = 1'b1;
         state_d   = IDLE;
         remain_d  = '0;
      end else if (state_q == LOAD_STALL) begin
         pc_hold   = 1'b1;
         ifd_hold  = 1'b1;
         de_bubble = 1'b1;
         remain_d  = remain_q - 4'd1;
         if (remain_q == 4'd1) begin
            state_d = IDLE;
         end
      end else if (hazard_hit) begin
         pc_hold   = 1'b1;
         ifd_hold  = 1'b1;
         de_bubble = 1'b1;
         if (LOAD_STALLS > 1) begin
            state_d  = LOAD_STALL;
            remain_d = INIT_REMAIN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   assign stall_state = reset ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   // Both counters stick at all-ones instead of wrapping
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (pc_hold && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (ifd_flush && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
